// File: rtl/common_pkg.sv
// Shared widths and types for the SRAM arbitration slice.
package common_pkg;
  localparam int RAM_ADDR_WIDTH  = 16;
  localparam int DATA_WIDTH      = 8;
  localparam int RAM_ARB_NUM_REQ = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } ram_arb_state_t;
endpackage

// File: rtl/mock_ram.sv
// Behavioural SRAM model with registered read data, used to close the loop around the arbiter.
module mock_ram #(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic          clock_i,
  input  logic [AW-1:0] ram_addr_i,
  input  logic [DW-1:0] ram_data_i,
  input  logic          ram_we_n_i,
  input  logic          ram_oe_n_i,
  output logic [DW-1:0] ram_data_o
);
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clock_i) begin
    if (!ram_we_n_i) mem[ram_addr_i] <= ram_data_i;
    if (!ram_oe_n_i) ram_data_o <= mem[ram_addr_i];
  end
endmodule

// File: rtl/ram_rr_select.sv
// Winner selection: requester 0 has strict priority, the rest rotate from rr_ptr_i.
module ram_rr_select
  import common_pkg::*;
#(
  parameter int NUM_REQ = RAM_ARB_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [IDX_W-1:0]   grant_o,
  output logic               valid_o
);
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  // Scan from the farthest offset down so the nearest request to rr_ptr_i wins.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    sum     = '0;
    idx     = '0;
    if (req_i[0]) begin
      valid_o = 1'b1;
    end else begin
      for (int off = NUM_REQ - 2; off >= 0; off--) begin
        sum = {1'b0, rr_ptr_i} + (IDX_W + 1)'(off);
        if (sum >= (IDX_W + 1)'(NUM_REQ)) sum = sum - (IDX_W + 1)'(NUM_REQ - 1);
        idx = sum[IDX_W-1:0];
        if (req_i[idx]) begin
          grant_o = idx;
          valid_o = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/ram_arbiter.sv
// Shares one external SRAM port among NUM_REQ requesters; one fixed 4-cycle access per grant.
module ram_arbiter
  import common_pkg::*;
#(
  parameter int NUM_REQ = RAM_ARB_NUM_REQ
) (
  input  logic                              clock_i,
  input  logic                              reset_n_i,
  input  logic [NUM_REQ-1:0]                req_i,
  input  logic [NUM_REQ-1:0]                we_i,
  input  logic [NUM_REQ*RAM_ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     wr_data_i,
  output logic [NUM_REQ-1:0]                ack_o,
  output logic [DATA_WIDTH-1:0]             rd_data_o,
  output logic                              busy_o,
  output logic [RAM_ADDR_WIDTH-1:0]         ram_addr_o,
  output logic [DATA_WIDTH-1:0]             ram_data_o,
  input  logic [DATA_WIDTH-1:0]             ram_data_i,
  output logic                              ram_we_n_o,
  output logic                              ram_oe_n_o
);
  localparam int IDX_W = $clog2(NUM_REQ);

  ram_arb_state_t              state_q, state_d;
  logic [IDX_W-1:0]            grant_q, grant_d, rr_ptr_q, rr_ptr_d, sel_idx;
  logic                        we_q, we_d, sel_valid;
  logic [NUM_REQ-1:0]          ack_q, ack_d;
  logic [DATA_WIDTH-1:0]       rd_data_q, rd_data_d, ram_data_q, ram_data_d;
  logic [RAM_ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic                        ram_we_n_q, ram_we_n_d, ram_oe_n_q, ram_oe_n_d;

  ram_rr_select #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_sel (
    .req_i    (req_i),
    .rr_ptr_i (rr_ptr_q),
    .grant_o  (sel_idx),
    .valid_o  (sel_valid)
  );

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_valid) state_d = ACCESS;
      ACCESS:  state_d = WAIT;
      WAIT:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin registers are loaded on the IDLE->ACCESS edge, so ram_addr_q doubles as the latched address.
  always_comb begin
    grant_d    = grant_q;
    we_d       = we_q;
    rr_ptr_d   = rr_ptr_q;
    ack_d      = '0;
    rd_data_d  = rd_data_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_we_n_d = 1'b1;
    ram_oe_n_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          grant_d    = sel_idx;
          we_d       = we_i[sel_idx];
          ram_addr_d = addr_i[int'(sel_idx)*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
          if (we_i[sel_idx]) begin
            ram_we_n_d = 1'b0;
            ram_data_d = wr_data_i[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
          end else begin
            ram_oe_n_d = 1'b0;
          end
          if (sel_idx != '0) begin
            if (sel_idx == IDX_W'(NUM_REQ - 1)) rr_ptr_d = IDX_W'(1);
            else                                rr_ptr_d = sel_idx + IDX_W'(1);
          end
        end
      end
      WAIT: begin
        if (!we_q) rd_data_d = ram_data_i;
        ack_d = NUM_REQ'(1) << grant_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      grant_q    <= '0;
      we_q       <= 1'b0;
      rr_ptr_q   <= IDX_W'(1);
      ack_q      <= '0;
      rd_data_q  <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_we_n_q <= 1'b1;
      ram_oe_n_q <= 1'b1;
    end else begin
      grant_q    <= grant_d;
      we_q       <= we_d;
      rr_ptr_q   <= rr_ptr_d;
      ack_q      <= ack_d;
      rd_data_q  <= rd_data_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_we_n_q <= ram_we_n_d;
      ram_oe_n_q <= ram_oe_n_d;
    end
  end

  assign ack_o      = ack_q;
  assign rd_data_o  = rd_data_q;
  assign busy_o     = (state_q != IDLE);
  assign ram_addr_o = ram_addr_q;
  assign ram_data_o = ram_data_q;
  assign ram_we_n_o = ram_we_n_q;
  assign ram_oe_n_o = ram_oe_n_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter closed around mock_ram.
module tb_ram_arbiter;
  import common_pkg::*;

  localparam int N  = 3;
  localparam int AW = RAM_ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, we, ack;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0]   rd_data, ram_wdata, ram_rdata;
  logic [AW-1:0]   ram_addr;
  logic            busy, ram_we_n, ram_oe_n;

  always #5 clk = ~clk;

  ram_arbiter #(.NUM_REQ(N)) dut (
    .clock_i(clk), .reset_n_i(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .wr_data_i(wdata), .ack_o(ack), .rd_data_o(rd_data), .busy_o(busy),
    .ram_addr_o(ram_addr), .ram_data_o(ram_wdata), .ram_data_i(ram_rdata),
    .ram_we_n_o(ram_we_n), .ram_oe_n_o(ram_oe_n)
  );

  mock_ram #(.AW(AW), .DW(DW)) u_ram (
    .clock_i(clk), .ram_addr_i(ram_addr), .ram_data_i(ram_wdata),
    .ram_we_n_i(ram_we_n), .ram_oe_n_i(ram_oe_n), .ram_data_o(ram_rdata)
  );

  typedef struct {
    int            idx;
    bit            is_rd;
    logic [DW-1:0] data;
    int            exp_cyc;
    int            gap;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model[int];
  int            errors = 0, checks = 0, cyc = 0, last_ack = -100;
  int            rem[N];
  int            oe_cnt = 0, we_cnt = 0, overlap = 0;
  logic [AW-1:0] we_addr;
  logic [DW-1:0] we_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected response for requester i; the model tracks memory in grant order.
  task automatic txn(int i, bit w, logic [AW-1:0] a, logic [DW-1:0] d, int exp_cyc, int gap);
    exp_t e;
    e.idx = i; e.is_rd = !w; e.exp_cyc = exp_cyc; e.gap = gap;
    if (w) begin model[int'(a)] = d; e.data = d; end
    else   e.data = model.exists(int'(a)) ? model[int'(a)] : '0;
    sb.push_back(e);
  endtask

  task automatic drive(int i, bit w, logic [AW-1:0] a, logic [DW-1:0] d, int n);
    we[i] = w;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
    rem[i] = n;
    req[i] = 1'b1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((req != '0 || sb.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("idle_timeout", 64'(sb.size()), 0);
    @(negedge clk);
  endtask

  // Strobe monitor
  initial forever begin
    @(negedge clk);
    if (!ram_we_n && !ram_oe_n) overlap++;
    if (rst_n) begin
      if (!ram_oe_n) oe_cnt++;
      if (!ram_we_n) begin
        we_cnt++;
        we_addr = ram_addr;
        we_data = ram_wdata;
      end
    end
  end

  // Scoreboard monitor
  initial forever begin
    @(negedge clk);
    if (ack != '0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack actual=%0b required=none", ack);
      end else begin
        exp_t e;
        logic [N-1:0] one;
        e = sb.pop_front();
        one = 1;
        chk("ack_grant", 64'(ack), 64'(one << e.idx));
        if (e.is_rd) chk("rd_data", 64'(rd_data), 64'(e.data));
        if (e.exp_cyc >= 0) chk("ack_latency", 64'(cyc), 64'(e.exp_cyc));
        if (e.gap > 0) chk("ack_gap", 64'(cyc - last_ack), 64'(e.gap));
      end
      last_ack = cyc;
    end
  end

  // Requester side: drop req in the ack cycle once its transaction count is used up.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (ack[i] && req[i]) begin
        rem[i]--;
        if (rem[i] <= 0) req[i] = 1'b0;
      end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int o0, w0, t;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit w;
    int i;

    rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
    for (int k = 0; k < N; k++) rem[k] = 0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 64'(ack), 0);
    chk("rst_rd_data", 64'(rd_data), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_ram_addr", 64'(ram_addr), 0);
    chk("rst_ram_data", 64'(ram_wdata), 0);
    chk("rst_we_n", 64'(ram_we_n), 1);
    chk("rst_oe_n", 64'(ram_oe_n), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Preload through requester 0 (leaves rr_ptr at 1)
    txn(0, 1, 16'h1234, 8'hA5, -1, 0); drive(0, 1, 16'h1234, 8'hA5, 1); wait_idle();
    txn(0, 1, 16'h0300, 8'h11, -1, 0); drive(0, 1, 16'h0300, 8'h11, 1); wait_idle();

    // Single read by requester 1
    o0 = oe_cnt;
    txn(1, 0, 16'h1234, 8'h00, cyc + 3, 0); drive(1, 0, 16'h1234, 8'h00, 1);
    @(negedge clk);
    chk("busy_in_access", 64'(busy), 1);
    wait_idle();
    chk("read_oe_cycles", 64'(oe_cnt - o0), 1);
    chk("rd_data_hold", 64'(rd_data), 64'h A5);

    // Single write by requester 2, then read back by requester 2
    w0 = we_cnt;
    txn(2, 1, 16'h0100, 8'h5A, cyc + 3, 0); drive(2, 1, 16'h0100, 8'h5A, 1);
    wait_idle();
    chk("write_we_cycles", 64'(we_cnt - w0), 1);
    chk("write_addr", 64'(we_addr), 64'h0100);
    chk("write_data", 64'(we_data), 64'h5A);
    txn(2, 0, 16'h0100, 8'h00, -1, 0); drive(2, 0, 16'h0100, 8'h00, 1); wait_idle();

    // Priority: all three at once
    drive(0, 0, 16'h1234, 8'h00, 1);
    drive(1, 0, 16'h0100, 8'h00, 1);
    drive(2, 0, 16'h0300, 8'h00, 1);
    txn(0, 0, 16'h1234, 8'h00, cyc + 3, 0);
    txn(1, 0, 16'h0100, 8'h00, -1, 4);
    txn(2, 0, 16'h0300, 8'h00, -1, 4);
    wait_idle();

    // Round-robin with continuous re-request
    drive(1, 0, 16'h1234, 8'h00, 3);
    drive(2, 0, 16'h0100, 8'h00, 3);
    txn(1, 0, 16'h1234, 8'h00, cyc + 3, 0);
    for (int k = 0; k < 5; k++)
      if (k % 2 == 0) txn(2, 0, 16'h0100, 8'h00, -1, 4);
      else            txn(1, 0, 16'h1234, 8'h00, -1, 4);
    wait_idle();

    // Move rr_ptr away from 1, then reset during an ACCESS write
    txn(1, 0, 16'h1234, 8'h00, -1, 0); drive(1, 0, 16'h1234, 8'h00, 1); wait_idle();
    drive(2, 1, 16'h0300, 8'hEE, 1);
    t = 0;
    while (ram_we_n !== 1'b0 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("reset_test_we_seen", 64'(ram_we_n), 0);
    rst_n = 1'b0;
    #1;
    chk("reset_we_async", 64'(ram_we_n), 1);
    chk("reset_busy", 64'(busy), 0);
    req = '0; rem[2] = 0;
    repeat (2) @(negedge clk);
    chk("reset_no_ack", 64'(ack), 0);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1, 0, 16'h0100, 8'h00, 1);
    drive(2, 0, 16'h1234, 8'h00, 1);
    txn(1, 0, 16'h0100, 8'h00, cyc + 3, 0);
    txn(2, 0, 16'h1234, 8'h00, -1, 4);
    wait_idle();
    txn(0, 0, 16'h0300, 8'h00, -1, 0); drive(0, 0, 16'h0300, 8'h00, 1); wait_idle();

    // Back-to-back random traffic over a small address window
    for (int k = 0; k < 16; k++) begin
      i = int'($urandom_range(0, N - 1));
      a = 16'h0010 + AW'($urandom_range(0, 7));
      d = DW'($urandom_range(0, 255));
      w = (!model.exists(int'(a))) || ($urandom_range(0, 1) == 1);
      t = 0;
      while (req != '0 && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) chk("random_req_timeout", 64'(req), 0);
      txn(i, w, a, d, -1, 0);
      drive(i, w, a, d, 1);
    end
    wait_idle();
    for (int k = 0; k < 8; k++) begin
      a = 16'h0010 + AW'(k);
      if (model.exists(int'(a))) begin
        txn(0, 0, a, 8'h00, -1, 0); drive(0, 0, a, 8'h00, 1); wait_idle();
      end
    end

    chk("strobe_overlap", 64'(overlap), 0);
    chk("scoreboard_empty", 64'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
